bram_burst_reader: RTL and testbench

Single-clock read initiator for one port of our true dual-port BRAM. On a start command it streams `length` consecutive words, beginning at `base_addr`, out of the BRAM onto a valid/ready stream with a last flag. It absorbs the BRAM's one-cycle registered read latency and downstream backpressure with an internal 4-entry buffer. It sits between a BRAM port (typically the port opposite a writer) and a stream consumer such as a packetiser or DMA.

---
 rtl/bram_burst_reader.sv | 131 +++++++++++++
 tb/tb_bram_burst_reader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_burst_reader.sv
// Burst read initiator for one BRAM port: streams `length` consecutive words
// from `base_addr` onto a valid/ready stream, absorbing BRAM latency and backpressure.
module bram_burst_reader #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_wr,
    input  logic [DATA_WIDTH-1:0] bram_data_in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH:0]   issue_left;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH:0]   pop_count;
    logic [ADDR_WIDTH:0]   start_len;
    logic                  issue_v;
    logic                  issue_v_d;

    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            occupancy;

    logic                  push;
    logic                  pop;
    logic                  can_issue;
    logic                  last_pop;

    assign bram_wr   = 1'b0;
    assign start_len = (length > MAX_LEN) ? MAX_LEN : length;
    assign push      = issue_v_d;
    assign out_valid = (occupancy != 3'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid && ((pop_count + (ADDR_WIDTH+1)'(1)) == len_r);
    assign last_pop  = pop && out_last;

    // Buffered words plus reads still in the address and BRAM stages must never
    // exceed the FIFO depth, so every issued read is guaranteed a slot.
    assign can_issue = (state == READ) &&
                       ((occupancy + 3'(issue_v) + 3'(issue_v_d)) < 3'd4);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bram_addr  <= '0;
            next_addr  <= '0;
            issue_left <= '0;
            len_r      <= '0;
            pop_count  <= '0;
            issue_v    <= 1'b0;
            issue_v_d  <= 1'b0;
        end else begin
            done      <= 1'b0;
            issue_v   <= 1'b0;
            issue_v_d <= issue_v;
            if (pop) pop_count <= pop_count + (ADDR_WIDTH+1)'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        next_addr  <= base_addr;
                        len_r      <= start_len;
                        issue_left <= start_len;
                        pop_count  <= '0;
                        state      <= (start_len == '0) ? DRAIN : READ;
                    end
                end
                READ: begin
                    if (can_issue) begin
                        bram_addr  <= next_addr;
                        next_addr  <= next_addr + ADDR_WIDTH'(1);
                        issue_v    <= 1'b1;
                        issue_left <= issue_left - (ADDR_WIDTH+1)'(1);
                        if (issue_left == (ADDR_WIDTH+1)'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (len_r == '0 || last_pop) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and occupancy are reset,
    // and out_data is masked while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bram_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            if (push && !pop)      occupancy <= occupancy + 3'd1;
            else if (!push && pop) occupancy <= occupancy - 3'd1;
        end
    end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader with a registered-read BRAM model
// holding mem[i] = i.
module tb_bram_burst_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_wr;
    logic [DW-1:0] bram_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [16];

    // Observations gathered by collect() for one burst
    logic [DW-1:0] q_data [$];
    bit            q_last [$];
    int            q_n    [$];
    int            busy_cnt, done_cnt, done_n, valid_cnt;
    int            stall_err, occ_err, wr_err;
    logic [AW-1:0] addr_at_1;

    always #5 clk = ~clk;

    always_ff @(posedge clk) bram_q <= mem[bram_addr];

    bram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .bram_addr(bram_addr), .bram_wr(bram_wr),
        .bram_data_in(bram_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        step();
        start     = 1'b0;
    endtask

    // Runs from the point just after the start edge (n=0) until done is seen,
    // stop_after handshakes happen, or max_cyc points elapse.
    task automatic collect(input int pct, input int max_cyc, input int stop_after,
                           input int restart_n, input bit restart_last);
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        logic          prev_last  = 1'b0;
        int            r;
        q_data.delete(); q_last.delete(); q_n.delete();
        busy_cnt = 0; done_cnt = 0; done_n = -1; valid_cnt = 0;
        stall_err = 0; occ_err = 0; wr_err = 0; addr_at_1 = 'x;
        for (int n = 0; n < max_cyc; n++) begin
            start = 1'b0;
            if (busy) busy_cnt++;
            if (out_valid) valid_cnt++;
            if (bram_wr !== 1'b0) wr_err++;
            if (int'(dut.occupancy) + int'(dut.issue_v) + int'(dut.issue_v_d) > 4) occ_err++;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
                stall_err++;
            if (n == 1) addr_at_1 = bram_addr;
            if (done) begin
                done_cnt++;
                done_n = n;
                break;
            end
            r = $urandom_range(99, 0);
            out_ready = (pct >= 100) ? 1'b1 : (r < pct);
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                q_n.push_back(n);
                if (restart_last && out_last) begin
                    start = 1'b1; base_addr = 4'd9; length = 5'd2;
                end
            end
            if (n == restart_n) begin
                start = 1'b1; base_addr = 4'd9; length = 5'd2;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (stop_after > 0 && q_data.size() == stop_after) return;
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        checks++;
        if ({busy, done, out_valid, out_last, bram_wr} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {busy, done, out_valid, out_last, bram_wr});
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_out_data got=%0h exp=0", out_data);
        end
        checks++;
        if (bram_addr !== '0) begin
            failures++;
            $display("FAIL reset_bram_addr got=%0h exp=0", bram_addr);
        end
    endtask

    task automatic test_basic;
        issue_start(4'd2, 5'd4);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_start got=%b exp=1", busy);
        end
        collect(100, 50, 0, -1, 1'b0);
        checks++;
        if (addr_at_1 !== 4'd2) begin
            failures++;
            $display("FAIL basic_bram_addr got=%0h exp=2", addr_at_1);
        end
        checks++;
        if (q_data.size() != 4) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=4", q_data.size());
        end
        for (int j = 0; j < 4 && j < q_data.size(); j++) begin
            checks++;
            if (q_data[j] !== DW'(2 + j) || q_n[j] != 3 + j || q_last[j] != (j == 3)) begin
                failures++;
                $display("FAIL basic_word[%0d] got data=%0h n=%0d last=%0d exp data=%0h n=%0d last=%0d",
                         j, q_data[j], q_n[j], q_last[j], 2 + j, 3 + j, j == 3);
            end
        end
        checks++;
        if (done_cnt != 1 || done_n != 7 || busy_cnt != 7) begin
            failures++;
            $display("FAIL basic_done got done_cnt=%0d done_n=%0d busy_cycles=%0d exp 1 7 7",
                     done_cnt, done_n, busy_cnt);
        end
    endtask

    task automatic test_wrap;
        issue_start(4'd14, 5'd4);
        collect(100, 50, 0, -1, 1'b0);
        checks++;
        if (q_data.size() != 4 || done_cnt != 1) begin
            failures++;
            $display("FAIL wrap_count got=%0d done_cnt=%0d exp 4 1", q_data.size(), done_cnt);
        end
        for (int j = 0; j < 4 && j < q_data.size(); j++) begin
            checks++;
            if (q_data[j] !== DW'((14 + j) % 16) || q_last[j] != (j == 3)) begin
                failures++;
                $display("FAIL wrap_word[%0d] got data=%0h last=%0d exp data=%0h last=%0d",
                         j, q_data[j], q_last[j], (14 + j) % 16, j == 3);
            end
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        issue_start(4'd0, 5'd16);
        collect(50, 600, 0, -1, 1'b0);
        checks++;
        if (q_data.size() != 16 || done_cnt != 1) begin
            failures++;
            $display("FAIL bp_count got=%0d done_cnt=%0d exp 16 1", q_data.size(), done_cnt);
        end
        for (int j = 0; j < 16 && j < q_data.size(); j++)
            if (q_data[j] !== DW'(j) || q_last[j] != (j == 15)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_order got bad_words=%0d exp 0", bad);
        end
        checks++;
        if (stall_err != 0 || occ_err != 0 || wr_err != 0) begin
            failures++;
            $display("FAIL bp_invariants got stall_err=%0d occ_err=%0d wr_err=%0d exp 0 0 0",
                     stall_err, occ_err, wr_err);
        end
    endtask

    task automatic test_zero;
        issue_start(4'd7, 5'd0);
        collect(100, 20, 0, -1, 1'b0);
        checks++;
        if (done_cnt != 1 || done_n != 1 || valid_cnt != 0 || busy_cnt != 1) begin
            failures++;
            $display("FAIL zero_len got done_cnt=%0d done_n=%0d valid=%0d busy=%0d exp 1 1 0 1",
                     done_cnt, done_n, valid_cnt, busy_cnt);
        end
    endtask

    task automatic test_clamp;
        int bad = 0;
        issue_start(4'd5, 5'd21);
        collect(100, 80, 0, -1, 1'b0);
        checks++;
        if (q_data.size() != 16 || done_n != 19) begin
            failures++;
            $display("FAIL clamp_count got=%0d done_n=%0d exp 16 19", q_data.size(), done_n);
        end
        for (int j = 0; j < 16 && j < q_data.size(); j++)
            if (q_data[j] !== DW'((5 + j) % 16) || q_last[j] != (j == 15)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clamp_data got bad_words=%0d exp 0", bad);
        end
    endtask

    task automatic test_start_busy;
        int bad = 0;
        issue_start(4'd3, 5'd6);
        collect(100, 60, 0, 4, 1'b1);
        checks++;
        if (q_data.size() != 6 || done_n != 9 || done_cnt != 1) begin
            failures++;
            $display("FAIL busy_start_count got=%0d done_n=%0d done_cnt=%0d exp 6 9 1",
                     q_data.size(), done_n, done_cnt);
        end
        for (int j = 0; j < 6 && j < q_data.size(); j++)
            if (q_data[j] !== DW'(3 + j)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_start_data got bad_words=%0d exp 0", bad);
        end
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_ignored got busy=%b valid=%b exp 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        int quiet_bad = 0;
        int bad = 0;
        issue_start(4'd4, 5'd8);
        collect(100, 50, 3, -1, 1'b0);
        checks++;
        if (q_data.size() != 3 || q_data[0] !== 8'd4 || q_data[2] !== 8'd6 || done_cnt != 0) begin
            failures++;
            $display("FAIL rstmid_pre got count=%0d done_cnt=%0d exp 3 0", q_data.size(), done_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0 || out_data !== '0 || bram_addr !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got flags=%b data=%0h addr=%0h exp 0000 0 0",
                     {busy, done, out_valid, out_last}, out_data, bram_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) quiet_bad++;
        end
        checks++;
        if (quiet_bad != 0) begin
            failures++;
            $display("FAIL rstmid_quiet got bad_cycles=%0d exp 0", quiet_bad);
        end
        issue_start(4'd10, 5'd8);
        collect(100, 50, 0, -1, 1'b0);
        checks++;
        if (q_data.size() != 8 || done_n != 11) begin
            failures++;
            $display("FAIL rstmid_rerun_count got=%0d done_n=%0d exp 8 11", q_data.size(), done_n);
        end
        for (int j = 0; j < 8 && j < q_data.size(); j++)
            if (q_data[j] !== DW'((10 + j) % 16) || q_last[j] != (j == 7)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstmid_rerun_data got bad_words=%0d exp 0", bad);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        test_reset();
        step();
        test_basic();
        repeat (2) step();
        test_wrap();
        repeat (2) step();
        test_backpressure();
        repeat (2) step();
        test_zero();
        repeat (2) step();
        test_clamp();
        repeat (2) step();
        test_start_busy();
        repeat (2) step();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
